// File: rtl/tdm_1_to_4_demux.sv
// -----------------------------------------------------------------------------
// tdm_1_to_4_demux
//
// De-interleaves a TDM sample stream (slot order 0,1,2,3) into four parallel
// channels. Incoming samples fill a working buffer; each completed four-slot
// frame moves to a held output buffer that the consumer drains with a
// valid/ready handshake. There is no input backpressure, so a frame that
// completes while the output buffer is still full is dropped and flagged.
//
// Optional feature macro: DEMUX_SYNC_CHECK_EN
//   defined   : in_frame seen at a non-zero slot abandons the partial frame,
//               restarts at slot 0 with that sample, and pulses sync_err.
//   undefined : in_frame is ignored, the slot counter free-runs on in_valid,
//               and sync_err is tied low.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_data    incoming TDM sample (WIDTH bits)
//   in_valid   in_data valid this cycle
//   in_frame   marks in_data as slot 0 (only meaningful with in_valid)
//   out0..out3 channels 0..3 of the last completed frame
//   out_valid  a completed frame is held on out0..out3
//   out_ready  consumer accepts the held frame when out_valid && out_ready
//   slot       slot index the next accepted sample will fill (registered)
//   sync_err   one-cycle pulse: frame-start misalignment detected
//   overrun    one-cycle pulse: completed frame dropped, output buffer full
// -----------------------------------------------------------------------------
module tdm_1_to_4_demux #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_frame,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       slot,
    output logic             sync_err,
    output logic             overrun
);

    logic [1:0]       slot_q,      slot_d;
    logic [WIDTH-1:0] w_q   [4];
    logic [WIDTH-1:0] w_d   [4];
    logic [WIDTH-1:0] out_q [4];
    logic [WIDTH-1:0] out_d [4];
    logic             out_valid_q, out_valid_d;
    logic             sync_err_q,  sync_err_d;
    logic             overrun_q,   overrun_d;

    // Resynchronisation request: a frame start arriving anywhere but slot 0.
    logic             resync;

`ifdef DEMUX_SYNC_CHECK_EN
    assign resync = in_valid && in_frame && (slot_q != 2'd0);
`else
    logic unused_in_frame;
    assign unused_in_frame = in_frame;
    assign resync          = 1'b0;
`endif

    always_comb begin
        slot_d      = slot_q;
        w_d         = w_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        sync_err_d  = 1'b0;
        overrun_d   = 1'b0;

        // Handshake first; a completion in the same cycle may re-set out_valid.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (in_valid) begin
            if (resync) begin
                // Partial frame abandoned; this sample starts a new frame.
                w_d[0]     = in_data;
                slot_d     = 2'd1;
                sync_err_d = 1'b1;
            end else begin
                w_d[slot_q] = in_data;
                slot_d      = slot_q + 2'd1;
                if (slot_q == 2'd3) begin
                    // Output buffer is free if empty or being drained this cycle.
                    if (!out_valid_q || out_ready) begin
                        out_d[0]    = w_q[0];
                        out_d[1]    = w_q[1];
                        out_d[2]    = w_q[2];
                        out_d[3]    = in_data;
                        out_valid_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q      <= 2'd0;
            out_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            slot_q      <= slot_d;
            out_valid_q <= out_valid_d;
            sync_err_q  <= sync_err_d;
            overrun_q   <= overrun_d;
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_buf
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    w_q[gi]   <= '0;
                    out_q[gi] <= '0;
                end else begin
                    w_q[gi]   <= w_d[gi];
                    out_q[gi] <= out_d[gi];
                end
            end
        end
    endgenerate

    assign out0      = out_q[0];
    assign out1      = out_q[1];
    assign out2      = out_q[2];
    assign out3      = out_q[3];
    assign out_valid = out_valid_q;
    assign slot      = slot_q;
    assign sync_err  = sync_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_tdm_1_to_4_demux.sv
// -----------------------------------------------------------------------------
// tb_tdm_1_to_4_demux
//
// Directed scenarios followed by randomized traffic, all compared every cycle
// against a queue-based frame model: accepted samples are pushed into a
// partial-frame queue, the slot is the queue length, and a queue of four
// becomes the held frame (or an overrun if the held frame was not drained).
// -----------------------------------------------------------------------------
module tb_tdm_1_to_4_demux;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_frame;
    logic [7:0] out0, out1, out2, out3;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] slot;
    logic       sync_err;
    logic       overrun;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    tdm_1_to_4_demux #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_frame  (in_frame),
        .out0      (out0),
        .out1      (out1),
        .out2      (out2),
        .out3      (out3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .slot      (slot),
        .sync_err  (sync_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [7:0] part[$];
    logic [7:0] held [4];
    logic       m_valid;
    logic       m_sync;
    logic       m_ovr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp)
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else
            pass_cnt++;
    endtask

    task automatic model_reset();
        part.delete();
        for (int i = 0; i < 4; i++) held[i] = 8'h00;
        m_valid = 1'b0;
        m_sync  = 1'b0;
        m_ovr   = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic f, input logic [7:0] d, input logic r);
        m_sync = 1'b0;
        m_ovr  = 1'b0;
        if (m_valid && r) m_valid = 1'b0;
        if (v) begin
`ifdef DEMUX_SYNC_CHECK_EN
            if (f && part.size() != 0) begin
                part.delete();
                m_sync = 1'b1;
            end
`endif
            part.push_back(d);
            if (part.size() == 4) begin
                if (!m_valid) begin
                    for (int i = 0; i < 4; i++) held[i] = part[i];
                    m_valid = 1'b1;
                    $display("frame delivered %02h %02h %02h %02h", held[0], held[1], held[2], held[3]);
                end else begin
                    m_ovr = 1'b1;
                end
                part.delete();
            end
        end
    endtask

    task automatic compare_all(input string tag);
        logic [1:0] exp_slot;
        exp_slot = 2'(part.size());
        check({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
        check({tag, ".slot"},      32'(slot),      32'(exp_slot));
        check({tag, ".sync_err"},  32'(sync_err),  32'(m_sync));
        check({tag, ".overrun"},   32'(overrun),   32'(m_ovr));
        check({tag, ".out0"},      32'(out0),      32'(held[0]));
        check({tag, ".out1"},      32'(out1),      32'(held[1]));
        check({tag, ".out2"},      32'(out2),      32'(held[2]));
        check({tag, ".out3"},      32'(out3),      32'(held[3]));
    endtask

    // One clock: drive inputs, step the model on the edge, compare 1 time unit later.
    task automatic cycle(input string tag, input logic v, input logic f,
                         input logic [7:0] d, input logic r);
        in_valid  = v;
        in_frame  = f;
        in_data   = d;
        out_ready = r;
        @(posedge clk);
        model_step(v, f, d, r);
        #1;
        compare_all(tag);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".out0"},      32'(out0),      32'h0);
        check({tag, ".out1"},      32'(out1),      32'h0);
        check({tag, ".out2"},      32'(out2),      32'h0);
        check({tag, ".out3"},      32'(out3),      32'h0);
        check({tag, ".out_valid"}, 32'(out_valid), 32'h0);
        check({tag, ".slot"},      32'(slot),      32'h0);
        check({tag, ".sync_err"},  32'(sync_err),  32'h0);
        check({tag, ".overrun"},   32'(overrun),   32'h0);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        check_zero(tag);
        model_reset();
        #2;
        rst = 1'b0;
    endtask

    logic [7:0] seq [8];

    initial begin
        rst       = 1'b1;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        in_frame  = 1'b0;
        out_ready = 1'b0;
        model_reset();
        #3;
        check_zero("reset");
        @(posedge clk);
        #2 rst = 1'b0;

        // Basic frame, consumer always ready
        cycle("t1", 1, 1, 8'h11, 1);
        cycle("t1", 1, 0, 8'h22, 1);
        cycle("t1", 1, 0, 8'h33, 1);
        cycle("t1", 1, 0, 8'h44, 1);
        check("t1.c_out0", 32'(out0), 32'h11);
        check("t1.c_out3", 32'(out3), 32'h44);
        check("t1.c_valid", 32'(out_valid), 32'h1);
        check("t1.c_slot", 32'(slot), 32'h0);
        cycle("t1", 0, 0, 8'h00, 1);
        check("t1.c_drop", 32'(out_valid), 32'h0);

        // Overrun: consumer stalled across two frames
        for (int i = 0; i < 8; i++) cycle("t2", 1, (i % 4) == 0, 8'(i + 1), 0);
        check("t2.c_ovr", 32'(overrun), 32'h1);
        check("t2.c_out0", 32'(out0), 32'h01);
        check("t2.c_out3", 32'(out3), 32'h04);
        cycle("t2", 0, 0, 8'h00, 0);
        check("t2.c_ovr_pulse", 32'(overrun), 32'h0);
        cycle("t2", 0, 0, 8'h00, 1);
        check("t2.c_drain", 32'(out_valid), 32'h0);

        // Gaps on in_valid
        cycle("t3", 1, 1, 8'hA0, 1);
        cycle("t3", 0, 0, 8'h00, 1);
        cycle("t3", 1, 0, 8'hA1, 1);
        cycle("t3", 0, 0, 8'h00, 1);
        cycle("t3", 0, 0, 8'h00, 1);
        cycle("t3", 1, 0, 8'hA2, 1);
        check("t3.c_slot3", 32'(slot), 32'h3);
        cycle("t3", 1, 0, 8'hA3, 1);
        check("t3.c_out2", 32'(out2), 32'hA2);

        // Misaligned frame start
        do_reset("t4rst");
        seq[0] = 8'h10; seq[1] = 8'h20; seq[2] = 8'h30;
        seq[3] = 8'h40; seq[4] = 8'h50; seq[5] = 8'h60;
        for (int i = 0; i < 6; i++) cycle("t4", 1, (i == 0) || (i == 2), seq[i], 1);
`ifdef DEMUX_SYNC_CHECK_EN
        check("t4.c_out0", 32'(out0), 32'h30);
        check("t4.c_out3", 32'(out3), 32'h60);
`else
        check("t4.c_out0", 32'(out0), 32'h10);
        check("t4.c_out3", 32'(out3), 32'h40);
`endif

        // Async reset mid-frame with a held frame
        do_reset("t5rst0");
        for (int i = 0; i < 7; i++) cycle("t5", 1, (i % 4) == 0, 8'(8'hC0 + i), 0);
        check("t5.c_slot", 32'(slot), 32'h3);
        do_reset("t5rst");
        for (int i = 0; i < 4; i++) cycle("t5b", 1, i == 0, 8'(8'hD0 + i), 1);
        check("t5b.c_out1", 32'(out1), 32'hD1);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic v, f, r;
            v = ($urandom_range(0, 9) < 7);
            f = (part.size() == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 15) == 0);
            r = $urandom_range(0, 1) == 1;
            cycle("rnd", v, f, 8'($urandom), r);
            if (n == 1500) do_reset("rndrst");
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/tdm_1_to_4_demux.md
# tdm_1_to_4_demux

Receive-side counterpart of the 4-to-1 mux: de-interleaves a time-division-multiplexed sample stream back into four parallel channels. Samples arrive one per valid cycle in slot order 0,1,2,3 and are collected into a working buffer. A completed four-slot frame is transferred to a held output buffer, which the consumer drains with a valid/ready handshake. Sits between a serial TDM link and the per-channel consumers.

## Interface
- WIDTH, 8, bit width of each sample/channel
- clk  input  1  rising-edge clock
- rst  input  1  reset; asynchronous, active-high
- in_data  input  WIDTH  incoming TDM sample
- in_valid  input  1  in_data valid this cycle
- in_frame  input  1  qualifies in_data as slot 0 (frame start); meaningful only with in_valid
- out0..out3  output  WIDTH each  channel 0..3 of last completed frame
- out_valid  output  1  completed frame held on out0..out3
- out_ready  input  1  consumer accepts frame when out_valid && out_ready
- slot  output  2  slot index the next accepted sample will fill
- sync_err  output  1  one-cycle pulse: frame-start misalignment detected
- overrun  output  1  one-cycle pulse: completed frame dropped, output buffer still full

## Operation
- Working buffer w0..w3 (WIDTH each), 2-bit slot counter, output buffer out0..out3 + out_valid.
- No backpressure on input: every in_valid sample is consumed; there is no in_ready.
- Accepted sample (in_valid=1) written to w[slot]; slot increments mod 4 (3 wraps to 0).
- Sample accepted in slot 3 completes the frame:
  - out_valid=0, or out_valid=1 && out_ready=1 same cycle: out0..out2 <= w0..w2, out3 <= in_data, out_valid <= 1.
  - out_valid=1 && out_ready=0: frame dropped, outputs unchanged, overrun pulses 1 cycle.
- out_valid && out_ready with no completion that cycle: out_valid <= 0; out0..out3 keep last values.
- in_valid=0: slot, working buffer unchanged.
- Frame sync (with DEMUX_SYNC_CHECK_EN): in_valid && in_frame && slot!=0 -> partial frame abandoned, sample written to w0, slot <= 1, sync_err pulses 1 cycle. in_valid && !in_frame && slot==0 -> accepted normally (no error; in_frame is advisory at slot 0 only when asserted elsewhere).
- Reset: slot=0, w0..w3=0, out0..out3=0, out_valid=0, sync_err=0, overrun=0. Reset mid-frame discards partial frame; reset while out_valid=1 discards held frame.

## Timing
- All state registered on rising clk; rst clears immediately, independent of clk.
- Latency: slot-3 sample accepted at edge N -> out_valid=1 and out0..out3 valid after edge N.
- Minimum frame period 4 cycles; consumer must hold out_ready within 4 cycles of out_valid to avoid overrun at full rate.
- sync_err, overrun asserted for exactly the cycle after the causing edge.
- slot output is the registered counter (no combinational path from inputs).
- Simultaneous resync sample and out_ready: handshake still completes (out_valid <= 0).

## Configuration
- DEMUX_SYNC_CHECK_EN defined: in_frame resynchronisation and sync_err as above.
- Undefined: in_frame ignored; slot counter free-runs on in_valid only; sync_err tied 0. All other behaviour identical.

## Test plan
- Reset, then samples 0x11,0x22,0x33,0x44 on 4 consecutive cycles with in_frame on first, out_ready=1 -> out0..out3=0x11,0x22,0x33,0x44, out_valid=1 for one cycle after 4th edge, slot back to 0.
- out_ready=0, two full frames (0x01..0x04, then 0x05..0x08) -> outputs hold 0x01..0x04, overrun pulses once after 8th sample; raise out_ready -> out_valid drops next edge.
- in_valid gaps: samples 0xA0,-,0xA1,-,-,0xA2,0xA3 -> frame 0xA0..0xA3 completes on 0xA3 edge; slot sequence 0,1,1,2,2,2,3,0.
- With DEMUX_SYNC_CHECK_EN: 0x10,0x20 then in_frame with 0x30, then 0x40,0x50,0x60 -> sync_err one cycle, frame 0x30,0x40,0x50,0x60 delivered; without macro: frame 0x10,0x20,0x30,0x40 delivered, sync_err stays 0.
- Assert rst asynchronously after slot 2 of a frame and while out_valid=1 -> all outputs 0 immediately, slot=0; following full frame delivered correctly.
